// File: rtl/add_pkg.sv
// Shared definitions for the shared-adder scheduler: FSM encoding and
// elaboration-time sizing helpers.
package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a 2-requester ID is still one bit wide.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/add_flexible_biterwidth.sv
// Unsigned adder with independent operand widths; the sum is one bit wider
// than the wider operand so a carry out is never lost.
module add_flexible_biterwidth
    import add_pkg::*;
#(
    parameter  int unsigned WIDTH_A   = 8,
    parameter  int unsigned WIDTH_B   = 8,
    localparam int unsigned WIDTH_OUT = 1 + max_u(WIDTH_A, WIDTH_B)
) (
    input  logic [WIDTH_A-1:0]   a_i,
    input  logic [WIDTH_B-1:0]   b_i,
    output logic [WIDTH_OUT-1:0] sum_c
);

    assign sum_c = WIDTH_OUT'(a_i) + WIDTH_OUT'(b_i);

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one adder among NUM_REQ requesters; returns
// each registered sum on a valid/ready port tagged with the owner's index.
module add_share_sched
    import add_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned WIDTH_A   = 8,
    parameter  int unsigned WIDTH_B   = 8,
    localparam int unsigned WIDTH_OUT = 1 + max_u(WIDTH_A, WIDTH_B),
    localparam int unsigned IDW       = clog2_min1(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH_A-1:0]   a_bus,
    input  logic [NUM_REQ*WIDTH_B-1:0]   b_bus,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH_OUT-1:0]         result,
    output logic [IDW-1:0]               res_id
);

    state_e                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         sel_q, sel_d;
    logic [WIDTH_A-1:0]     op_a_q, op_a_d;
    logic [WIDTH_B-1:0]     op_b_q, op_b_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   res_valid_q, res_valid_d;
    logic [WIDTH_OUT-1:0]   result_q, result_d;
    logic [IDW-1:0]         res_id_q, res_id_d;

    logic [WIDTH_A-1:0]     a_arr [NUM_REQ];
    logic [WIDTH_B-1:0]     b_arr [NUM_REQ];
    logic [IDW-1:0]         pick_c;
    logic                   any_req_c;
    logic [WIDTH_OUT-1:0]   sum_c;
    logic                   do_grant;

    // Unpack the operand buses into per-requester lanes.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign a_arr[g] = a_bus[g*WIDTH_A +: WIDTH_A];
        assign b_arr[g] = b_bus[g*WIDTH_B +: WIDTH_B];
    end

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (v == IDW'(NUM_REQ - 1)) ? '0 : v + IDW'(1);
    endfunction

    // First asserted request at or above p, wrapping past the top index.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     p);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] pick;
        logic           hit;
        idx  = p;
        pick = p;
        hit  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && r[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    assign any_req_c = |req;
    assign pick_c    = rr_pick(req, ptr_q);

    add_flexible_biterwidth #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_c (sum_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_d       = '0;
        res_valid_d = res_valid_q;
        result_d    = result_q;
        res_id_d    = res_id_q;
        do_grant    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                do_grant = any_req_c;
            end
            ST_ADD: begin
                result_d    = sum_c;
                res_id_d    = sel_q;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    do_grant    = any_req_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Arbitration is shared by the idle path and the back-to-back accept path.
        if (do_grant) begin
            sel_d   = pick_c;
            op_a_d  = a_arr[pick_c];
            op_b_d  = b_arr[pick_c];
            gnt_d   = NUM_REQ'(1) << pick_c;
            ptr_d   = wrap_inc(pick_c);
            state_d = ST_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            res_id_q    <= res_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign res_id    = res_id_q;

endmodule
